// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the game-flow sequencer:
//               screen states, char ROM text pages, frame counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        MENU      = 2'd0,
        PLAYING   = 2'd1,
        LEVEL_UP  = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [1:0] PAGE_TITLE = 2'd0;
    localparam logic [1:0] PAGE_LEVEL = 2'd1;
    localparam logic [1:0] PAGE_LOSE  = 2'd2;
    localparam logic [1:0] PAGE_WIN   = 2'd3;

    localparam int FRAME_CNT_W = 16;

    // Larger of two integers, used to size the shared frame timers
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Signal bundle between the game sequencer and the VGA
//               pipeline / game logic. The sequencer uses the master view,
//               the surrounding pipeline uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;
    import game_pkg::*;

    logic                   vblnk;
    logic                   btn_start;
    logic                   player_dead;
    logic                   level_done;
    logic                   start_game;
    logic [1:0]             game_state;
    logic [1:0]             text_page;
    logic                   text_visible;
    logic [2:0]             level;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  vblnk, btn_start, player_dead, level_done,
        output start_game, game_state, text_page, text_visible, level, frame_cnt
    );

    modport slave (
        output vblnk, btn_start, player_dead, level_done,
        input  start_game, game_state, text_page, text_visible, level, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/game_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Start-button conditioner. Two-flop synchronizer, a counter
//               that accepts a level change only after DEBOUNCE_FRAMES
//               consecutive disagreeing frame samples, and a press strobe
//               that fires on the same sample that accepts a 0->1 change.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic sample_en,
    input  wire logic btn_in,
    output logic      btn_level,
    output logic      press
);

    localparam int c_cnt_w = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_FRAMES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differ;
    logic               w_accept;

    assign w_differ  = (r_sync2 != r_level);
    // Press is combinational so the FSM sees it on the very tick it is accepted
    assign w_accept  = sample_en & w_differ & (r_cnt == c_cnt_last);
    assign press     = w_accept & r_sync2;
    assign btn_level = r_level;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing frame samples; any agreeing sample restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (sample_en) begin
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + c_cnt_w'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Frame-synchronous game-flow controller. Walks MENU ->
//               PLAYING -> LEVEL_UP / GAME_OVER, changing screens only on
//               the vertical-blank tick so the display never tears. Drives
//               the start_game gate, char ROM page and blinking text enable.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int BLINK_FRAMES    = 30,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int LEVELUP_FRAMES  = 120,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int MAX_LEVEL       = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    game_sequencer_if.master  bus
);

    // One timer width covers every frame-count duration
    localparam int c_tmr_max = max_of(max_of(BLINK_FRAMES, LEVELUP_FRAMES),
                                      max_of(GAMEOVER_FRAMES, DEBOUNCE_FRAMES));
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

    localparam logic [c_tmr_w-1:0] c_blink_last = c_tmr_w'(BLINK_FRAMES - 1);
    localparam logic [c_tmr_w-1:0] c_lu_last    = c_tmr_w'(LEVELUP_FRAMES - 1);
    localparam logic [c_tmr_w-1:0] c_go_last    = c_tmr_w'(GAMEOVER_FRAMES - 1);
    localparam logic [2:0]         c_max_level  = 3'(MAX_LEVEL);

    logic                   r_vblnk_d;
    logic                   w_tick;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_dead_f;
    logic                   r_done_f;
    logic                   w_dead;
    logic                   w_done;
    logic                   w_press;

    game_state_t            r_state,  w_state_nx;
    logic [2:0]             r_level,  w_level_nx;
    logic [1:0]             r_page,   w_page_nx;
    logic                   r_vis,    w_vis_nx;
    logic                   r_start,  w_start_nx;
    logic [c_tmr_w-1:0]     r_timer,  w_timer_nx;
    logic [c_tmr_w-1:0]     r_blink,  w_blink_nx;

    assign w_tick = bus.vblnk & ~r_vblnk_d;
    // A pulse landing on the tick cycle itself still counts at that tick
    assign w_dead = r_dead_f | bus.player_dead;
    assign w_done = r_done_f | bus.level_done;

    btn_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (w_tick),
        .btn_in    (bus.btn_start),
        .btn_level (),
        .press     (w_press)
    );

    // Vblank edge detect and free-running frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_d   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vblnk_d <= bus.vblnk;
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Hold gameplay events until the next tick, then drop them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dead_f <= 1'b0;
            r_done_f <= 1'b0;
        end else if (w_tick) begin
            r_dead_f <= 1'b0;
            r_done_f <= 1'b0;
        end else begin
            if (bus.player_dead) r_dead_f <= 1'b1;
            if (bus.level_done)  r_done_f <= 1'b1;
        end
    end

    // Screen state, timers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MENU;
            r_level <= 3'd0;
            r_page  <= PAGE_TITLE;
            r_vis   <= 1'b1;
            r_start <= 1'b0;
            r_timer <= '0;
            r_blink <= '0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            r_page  <= w_page_nx;
            r_vis   <= w_vis_nx;
            r_start <= w_start_nx;
            r_timer <= w_timer_nx;
            r_blink <= w_blink_nx;
        end
    end

    // Next-state and output decode, evaluated only on frame ticks
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_page_nx  = r_page;
        w_vis_nx   = r_vis;
        w_timer_nx = r_timer;
        w_blink_nx = r_blink;

        if (w_tick) begin
            case (r_state)
                MENU: begin
                    if (w_press) begin
                        w_state_nx = PLAYING;
                        w_level_nx = 3'd1;
                        w_vis_nx   = 1'b0;
                        w_timer_nx = '0;
                    end else if (r_blink == c_blink_last) begin
                        w_blink_nx = '0;
                        w_vis_nx   = ~r_vis;
                    end else begin
                        w_blink_nx = r_blink + c_tmr_w'(1);
                    end
                end
                PLAYING: begin
                    if (w_dead) begin
                        w_state_nx = GAME_OVER;
                        w_page_nx  = PAGE_LOSE;
                        w_vis_nx   = 1'b1;
                        w_timer_nx = '0;
                    end else if (w_done && (r_level >= c_max_level)) begin
                        w_state_nx = GAME_OVER;
                        w_page_nx  = PAGE_WIN;
                        w_vis_nx   = 1'b1;
                        w_timer_nx = '0;
                    end else if (w_done) begin
                        w_state_nx = LEVEL_UP;
                        w_page_nx  = PAGE_LEVEL;
                        w_vis_nx   = 1'b1;
                        w_timer_nx = '0;
                    end
                end
                LEVEL_UP: begin
                    if (r_timer == c_lu_last) begin
                        w_state_nx = PLAYING;
                        w_level_nx = (r_level < c_max_level) ? r_level + 3'd1 : r_level;
                        w_vis_nx   = 1'b0;
                        w_timer_nx = '0;
                    end else begin
                        w_timer_nx = r_timer + c_tmr_w'(1);
                    end
                end
                GAME_OVER: begin
                    if (w_press || (r_timer == c_go_last)) begin
                        w_state_nx = MENU;
                        w_level_nx = 3'd0;
                        w_page_nx  = PAGE_TITLE;
                        w_vis_nx   = 1'b1;
                        w_timer_nx = '0;
                        w_blink_nx = '0;
                    end else begin
                        w_timer_nx = r_timer + c_tmr_w'(1);
                    end
                end
                default: begin
                    w_state_nx = MENU;
                end
            endcase
        end

        w_start_nx = (w_state_nx == PLAYING);
    end

    assign bus.start_game   = r_start;
    assign bus.game_state   = r_state;
    assign bus.text_page    = r_page;
    assign bus.text_visible = r_vis;
    assign bus.level        = r_level;
    assign bus.frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed bench for game_sequencer with short frame timers.
//               Each frame is a few low clocks followed by a vblnk rise;
//               outputs are sampled on the falling edge after the tick edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   exp_fcnt;

    game_sequencer_if bus_if ();

    game_sequencer #(
        .BLINK_FRAMES    (2),
        .DEBOUNCE_FRAMES (2),
        .LEVELUP_FRAMES  (4),
        .GAMEOVER_FRAMES (6),
        .MAX_LEVEL       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: low phase, then vblnk rises; returns one falling edge after the tick edge
    task automatic frame();
        @(negedge clk) bus_if.vblnk = 1'b0;
        repeat (5) @(negedge clk);
        bus_if.vblnk = 1'b1;
        @(negedge clk);
        exp_fcnt++;
    endtask

    task automatic pulse(input logic dead, input logic done);
        @(negedge clk);
        bus_if.player_dead = dead;
        bus_if.level_done  = done;
        @(negedge clk);
        bus_if.player_dead = 1'b0;
        bus_if.level_done  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, bus_if.game_state,   16'd0);
        check({tag, "_start"}, bus_if.start_game,   16'd0);
        check({tag, "_page"},  bus_if.text_page,    16'd0);
        check({tag, "_vis"},   bus_if.text_visible, 16'd1);
        check({tag, "_level"}, bus_if.level,        16'd0);
        check({tag, "_fcnt"},  bus_if.frame_cnt,    16'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_fcnt = 0;
        rst_n = 1'b0;
        bus_if.vblnk       = 1'b0;
        bus_if.btn_start   = 1'b0;
        bus_if.player_dead = 1'b0;
        bus_if.level_done  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Idle menu: blink toggles every 2 frames
        frame(); frame();
        check("blink_lo", bus_if.text_visible, 16'd0);
        frame(); frame();
        check("blink_hi", bus_if.text_visible, 16'd1);
        frame();
        check("idle_fcnt",  bus_if.frame_cnt,  16'(exp_fcnt));
        check("idle_fcnt5", bus_if.frame_cnt,  16'd5);
        check("idle_state", bus_if.game_state, 16'd0);
        check("idle_start", bus_if.start_game, 16'd0);
        check("idle_level", bus_if.level,      16'd0);

        // Single-frame hold and bounce never qualify as a press
        bus_if.btn_start = 1'b1; frame();
        bus_if.btn_start = 1'b0; frame();
        bus_if.btn_start = 1'b1; frame();
        bus_if.btn_start = 1'b0; frame();
        check("bounce_state", bus_if.game_state, 16'd0);

        // Two-frame hold starts the game on the second tick
        bus_if.btn_start = 1'b1; frame();
        check("hold1_state", bus_if.game_state, 16'd0);
        frame();
        check("play_state", bus_if.game_state, 16'd1);
        check("play_level", bus_if.level,      16'd1);
        check("play_start", bus_if.start_game, 16'd1);
        check("play_vis",   bus_if.text_visible, 16'd0);
        bus_if.btn_start = 1'b0;
        frame(); frame();
        check("play_hold", bus_if.game_state, 16'd1);

        // Level complete mid-frame -> LEVEL_UP for 4 ticks
        pulse(1'b0, 1'b1);
        check("lu_wait_tick", bus_if.game_state, 16'd1);
        frame();
        check("lu_state", bus_if.game_state,   16'd2);
        check("lu_page",  bus_if.text_page,    16'd1);
        check("lu_vis",   bus_if.text_visible, 16'd1);
        check("lu_start", bus_if.start_game,   16'd0);
        frame(); frame(); frame();
        check("lu_tick3", bus_if.game_state, 16'd2);
        frame();
        check("lu_exit_state", bus_if.game_state, 16'd1);
        check("lu_exit_level", bus_if.level,      16'd2);
        check("lu_exit_start", bus_if.start_game, 16'd1);

        // Dead and done in the same frame: dead wins
        pulse(1'b1, 1'b1);
        frame();
        check("lose_state", bus_if.game_state,   16'd3);
        check("lose_page",  bus_if.text_page,    16'd2);
        check("lose_vis",   bus_if.text_visible, 16'd1);
        check("lose_start", bus_if.start_game,   16'd0);

        // GAME_OVER times out after 6 ticks
        repeat (5) frame();
        check("go_tick5", bus_if.game_state, 16'd3);
        frame();
        check("go_to_state", bus_if.game_state,   16'd0);
        check("go_to_level", bus_if.level,        16'd0);
        check("go_to_page",  bus_if.text_page,    16'd0);
        check("go_to_vis",   bus_if.text_visible, 16'd1);
        check("go_to_fcnt",  bus_if.frame_cnt,    16'(exp_fcnt));

        // Second game up to the last level, then win
        bus_if.btn_start = 1'b1; frame(); frame();
        check("g2_state", bus_if.game_state, 16'd1);
        check("g2_level", bus_if.level,      16'd1);
        bus_if.btn_start = 1'b0;
        pulse(1'b0, 1'b1);
        frame();
        check("g2_lu", bus_if.game_state, 16'd2);
        repeat (4) frame();
        check("g2_l2_state", bus_if.game_state, 16'd1);
        check("g2_l2_level", bus_if.level,      16'd2);
        pulse(1'b0, 1'b1);
        frame();
        check("win_state", bus_if.game_state, 16'd3);
        check("win_page",  bus_if.text_page,  16'd3);
        check("win_level", bus_if.level,      16'd2);

        // Press held from GAME_OVER frame 1 exits at tick 2
        bus_if.btn_start = 1'b1; frame();
        check("gop_tick1", bus_if.game_state, 16'd3);
        frame();
        check("gop_state", bus_if.game_state, 16'd0);
        check("gop_level", bus_if.level,      16'd0);
        check("gop_page",  bus_if.text_page,  16'd0);
        bus_if.btn_start = 1'b0;
        frame(); frame();

        // Third game into LEVEL_UP, then asynchronous reset
        bus_if.btn_start = 1'b1; frame(); frame();
        bus_if.btn_start = 1'b0;
        check("g3_state", bus_if.game_state, 16'd1);
        pulse(1'b0, 1'b1);
        frame(); frame();
        check("g3_lu", bus_if.game_state, 16'd2);
        #2;
        rst_n = 1'b0;
        bus_if.vblnk = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_fcnt = 0;

        // Death pulses in MENU must be dropped, not carried into PLAYING
        pulse(1'b1, 1'b0);
        frame();
        check("menu_dead_state", bus_if.game_state, 16'd0);
        bus_if.btn_start = 1'b1;
        pulse(1'b1, 1'b0);
        frame(); frame();
        bus_if.btn_start = 1'b0;
        check("post_state", bus_if.game_state, 16'd1);
        frame();
        check("post_hold", bus_if.game_state, 16'd1);
        check("post_fcnt", bus_if.frame_cnt,  16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
